// File: rtl/button_debouncer_pkg.sv
// Shared constants and FSM state encoding for the button debouncer.
// Debounce time is derived from the board clock so STABLE_CYCLES tracks CLK_HZ.
package button_debouncer_pkg;

   localparam int CLK_HZ                = 50_000_000;
   localparam int DEBOUNCE_MS           = 10;
   localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

endpackage

// File: rtl/button_debouncer_debounce_cell.sv
// One-bit synchroniser + counter debounce FSM; dout moves STABLE_CYCLES+3 edges after a clean change.
// Optional BUTTON_DEBOUNCER_PULSE_EN adds registered rise/fall pulses; no backpressure.
module debounce_cell
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
`ifdef BUTTON_DEBOUNCER_PULSE_EN
   ,
   output logic rise_pulse,
   output logic fall_pulse
`endif
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dout_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_LOW;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dout  <= dout_nxt;
      end
   end

   // Any disagreement with the pending level drops back to the settled state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dout_nxt  = dout;
      case (state)
         S_LOW: begin
            if (sync2) begin
               state_nxt = S_WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         S_WAIT_HIGH: begin
            if (!sync2) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
               dout_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!sync2) begin
               state_nxt = S_WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         S_WAIT_LOW: begin
            if (sync2) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
               dout_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
            dout_nxt  = 1'b0;
         end
      endcase
   end

`ifdef BUTTON_DEBOUNCER_PULSE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= dout_nxt & ~dout;
         fall_pulse <= ~dout_nxt & dout;
      end
   end
`endif

endmodule

// File: rtl/button_debouncer.sv
// WIDTH independent button debouncers; each dout bit settles STABLE_CYCLES+3 edges after din.
// BUTTON_DEBOUNCER_PULSE_EN adds rise_pulse/fall_pulse outputs; no backpressure.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
`ifdef BUTTON_DEBOUNCER_PULSE_EN
   ,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
`endif
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      debounce_cell #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_cell (
         .clk       (clk),
         .rst_n     (rst_n),
         .din       (din[i]),
         .dout      (dout[i])
`ifdef BUTTON_DEBOUNCER_PULSE_EN
         ,
         .rise_pulse(rise_pulse[i]),
         .fall_pulse(fall_pulse[i])
`endif
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: 2-bit debouncer with STABLE_CYCLES=4 and a 1-bit instance with STABLE_CYCLES=1.
module tb_button_debouncer;

   logic       clk;
   logic       rst_n;
   logic [1:0] din0;
   logic [1:0] dout0;
   logic       din1;
   logic       dout1;
`ifdef BUTTON_DEBOUNCER_PULSE_EN
   logic [1:0] rise0, fall0;
   logic       rise1, fall1;
`endif

   int checks = 0;
   int errors = 0;

   button_debouncer #(.WIDTH(2), .STABLE_CYCLES(4)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din0),
      .dout      (dout0)
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      ,
      .rise_pulse(rise0),
      .fall_pulse(fall0)
`endif
   );

   button_debouncer #(.WIDTH(1), .STABLE_CYCLES(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din1),
      .dout      (dout1)
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      ,
      .rise_pulse(rise1),
      .fall_pulse(fall1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      din0  = 2'b00;
      din1  = 1'b0;
      step(3);
      check_eq("rst_dout0", 32'(dout0), 32'h0);
      check_eq("rst_dout1", 32'(dout1), 32'h0);
      rst_n = 1'b1;

      // idle: no input activity
      for (int i = 0; i < 20; i++) begin
         step(1);
         check_eq("idle_dout0", 32'(dout0), 32'h0);
      end

      // clean rise on bit 0 only
      din0 = 2'b01;
      step(6);
      check_eq("rise_e6", 32'(dout0), 32'h0);
      step(1);
      check_eq("rise_e7", 32'(dout0), 32'h1);
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      check_eq("rise_pulse_e7", 32'(rise0), 32'h1);
`endif
      step(1);
      check_eq("rise_e8", 32'(dout0), 32'h1);
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      check_eq("rise_pulse_e8", 32'(rise0), 32'h0);
`endif
      din0 = 2'b00;
      step(6);
      check_eq("fall_e6", 32'(dout0), 32'h1);
      step(1);
      check_eq("fall_e7", 32'(dout0), 32'h0);
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      check_eq("fall_pulse_e7", 32'(fall0), 32'h1);
`endif

      // bouncing: 3 high, 1 low, five times, then held high
      for (int r = 0; r < 5; r++) begin
         din0 = 2'b01;
         for (int k = 0; k < 3; k++) begin
            step(1);
            check_eq("bounce_hi", 32'(dout0), 32'h0);
         end
         din0 = 2'b00;
         step(1);
         check_eq("bounce_lo", 32'(dout0), 32'h0);
      end
      din0 = 2'b01;
      step(6);
      check_eq("settle_e6", 32'(dout0), 32'h0);
      step(1);
      check_eq("settle_e7", 32'(dout0), 32'h1);
      din0 = 2'b00;
      step(7);
      check_eq("settle_fall", 32'(dout0), 32'h0);

      // both bits together after a fresh reset
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      din0 = 2'b11;
      step(6);
      check_eq("both_rise_e6", 32'(dout0), 32'h0);
      step(1);
      check_eq("both_rise_e7", 32'(dout0), 32'h3);
      din0 = 2'b00;
      step(6);
      check_eq("both_fall_e6", 32'(dout0), 32'h3);
      step(1);
      check_eq("both_fall_e7", 32'(dout0), 32'h0);
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      check_eq("both_fall_pulse_e7", 32'(fall0), 32'h3);
      step(1);
      check_eq("both_fall_pulse_e8", 32'(fall0), 32'h0);
`endif

      // async reset in the middle of a WAIT_LOW count on bit 1
      din0 = 2'b10;
      step(7);
      check_eq("b1_high", 32'(dout0), 32'h2);
      din0 = 2'b00;
      step(4);
      check_eq("b1_wait_low", 32'(dout0), 32'h2);
      #2 rst_n = 1'b0;
      #1 check_eq("async_rst", 32'(dout0), 32'h0);
      din0 = 2'b10;
      @(negedge clk);
      rst_n = 1'b1;
      step(6);
      check_eq("post_rst_e6", 32'(dout0), 32'h0);
      step(1);
      check_eq("post_rst_e7", 32'(dout0), 32'h2);
      check_eq("dut1_quiet", 32'(dout1), 32'h0);

      // STABLE_CYCLES=1 instance
      din1 = 1'b1;
      step(3);
      check_eq("sc1_rise_e3", 32'(dout1), 32'h0);
      step(1);
      check_eq("sc1_rise_e4", 32'(dout1), 32'h1);
`ifdef BUTTON_DEBOUNCER_PULSE_EN
      check_eq("sc1_rise_pulse", 32'(rise1), 32'h1);
`endif
      din1 = 1'b0;
      step(3);
      check_eq("sc1_fall_e3", 32'(dout1), 32'h1);
      step(1);
      check_eq("sc1_fall_e4", 32'(dout1), 32'h0);
      din1 = 1'b1;
      step(1);
      din1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check_eq("sc1_glitch", 32'(dout1), 32'h0);
      end
      check_eq("dut0_hold", 32'(dout0), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
